// File: rtl/fft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fft_consts
// Shared constants and types for the FFT datapath and its address controller.
//   DW, FP_BITS, FRAC_BITS, complex_t : sample format used by the datapath.
//   LOG2N_DEF, RD_LAT_DEF, BFU_LAT_DEF : controller parameter defaults.
//   fft_ctrl_state_t                    : controller FSM states.
//   stage_width / bfly_addr_a / bfly_tw : helpers for stage-counter sizing and
//                                         radix-2 DIT butterfly addressing.
// -----------------------------------------------------------------------------
package fft_consts;

  localparam int DW        = 16;
  localparam int FP_BITS   = 2 * DW;
  localparam int FRAC_BITS = 15;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } complex_t;

  localparam int LOG2N_DEF   = 10;
  localparam int RD_LAT_DEF  = 1;
  localparam int BFU_LAT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT,
    ST_DRAIN
  } fft_ctrl_state_t;

  // Width of the stage index; never below one bit.
  function automatic int unsigned stage_width(int unsigned log2n);
    return (log2n > 1) ? $clog2(log2n) : 1;
  endfunction

  // Lower operand address of butterfly k in stage s: the group index k>>s is
  // spread to a stride of 2h, the in-group offset k&(h-1) is kept as is.
  function automatic int unsigned bfly_addr_a(int unsigned k, int unsigned s);
    return ((k >> s) << (s + 1)) | (k & ((32'd1 << s) - 1));
  endfunction

  // Twiddle exponent for butterfly k in stage s of an N = 2^log2n transform.
  function automatic int unsigned bfly_tw(int unsigned k, int unsigned s,
                                          int unsigned log2n);
    return (k & ((32'd1 << s) - 1)) << (log2n - 1 - s);
  endfunction

endpackage

// File: rtl/fft_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_ctrl_if
// Control/address bundle between the FFT controller and its environment.
//   start            : one-cycle transform request        (env  -> ctrl)
//   busy, done       : run status / completion pulse        (ctrl -> env)
//   rd_en, rd_addr_* : operand-pair read strobe/addresses   (ctrl -> env)
//   tw_idx           : twiddle ROM index aligned with rd_en (ctrl -> env)
//   wr_en, wr_addr_* : write-back strobe/addresses          (ctrl -> env)
//   stage            : current stage index                  (ctrl -> env)
// Modports: master = controller side, slave = memory/system side.
// -----------------------------------------------------------------------------
interface fft_ctrl_if #(
  parameter int LOG2N = fft_consts::LOG2N_DEF
);
  import fft_consts::*;

  localparam int STW = stage_width(LOG2N);

  logic             start;
  logic             busy;
  logic             done;
  logic             rd_en;
  logic [LOG2N-1:0] rd_addr_a;
  logic [LOG2N-1:0] rd_addr_b;
  logic [LOG2N-2:0] tw_idx;
  logic             wr_en;
  logic [LOG2N-1:0] wr_addr_a;
  logic [LOG2N-1:0] wr_addr_b;
  logic [STW-1:0]   stage;

  modport master (
    input  start,
    output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

  modport slave (
    output start,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_idx,
           wr_en, wr_addr_a, wr_addr_b, stage
  );

endinterface

// File: rtl/fft_addr_dly.sv
// -----------------------------------------------------------------------------
// fft_addr_dly
// Fixed-depth shift line carrying {valid, data}; output appears DEPTH cycles
// after input. Synchronous clear empties the line and zeroes its contents.
//   clk    : clock
//   clr_i  : synchronous clear, active high
//   vld_i  : entry valid,   data_i : entry payload
//   vld_o  : exit valid,    data_o : exit payload
//   pend_o : a valid entry is still travelling behind the exit slot
// -----------------------------------------------------------------------------
module fft_addr_dly #(
  parameter int DEPTH = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] data_o,
  output logic             pend_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: sequential state is written with <= so every stage samples the
  // previous stage's old value on the same edge; = would collapse the line.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      vld_q <= '0;
      // NOTE: the payload is cleared as well, not just the valid bits, so the
      // write addresses read zero right after a clear.
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

  generate
    if (DEPTH > 1) begin : g_pend
      assign pend_o = |vld_q[DEPTH-2:0];
    end else begin : g_no_pend
      assign pend_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/fft_ctrl.sv
// -----------------------------------------------------------------------------
// fft_ctrl
// Address/sequence controller for an in-place radix-2 DIT FFT over a
// bit-reversed sample memory. Issues one butterfly read per RUN cycle, emits
// matching write-backs PIPE_LAT = RD_LAT + BFU_LAT cycles later, pulses done.
//   clk : clock (posedge)
//   rst : synchronous, active-high reset
//   bus : fft_ctrl_if.master (start in; busy/done/rd_*/tw_idx/wr_*/stage out)
// Parameters: LOG2N (2..12), RD_LAT, BFU_LAT. The bus instance must use the
// same LOG2N.
// Build option: FFT_CTRL_HAZARD_EN -- when defined, each non-final stage is
// followed by a WAIT until its last write-back has issued, so the next stage
// never reads stale data. When undefined, stages run back to back and
// N/2 > PIPE_LAT must hold.
// -----------------------------------------------------------------------------
module fft_ctrl
  import fft_consts::*;
#(
  parameter int LOG2N   = LOG2N_DEF,
  parameter int RD_LAT  = RD_LAT_DEF,
  parameter int BFU_LAT = BFU_LAT_DEF
) (
  input logic        clk,
  input logic        rst,
  fft_ctrl_if.master bus
);

  localparam int PIPE_LAT = RD_LAT + BFU_LAT;
  localparam int KW       = LOG2N - 1;
  localparam int STW      = stage_width(LOG2N);

  localparam logic [KW-1:0]  K_LAST     = '1;  // N/2 - 1
  localparam logic [STW-1:0] LAST_STAGE = STW'(LOG2N - 1);

  fft_ctrl_state_t  state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [STW-1:0]   stage_q, stage_d;
  logic             rd_en_q, rd_en_d;
  logic [LOG2N-1:0] rd_a_q, rd_a_d;
  logic [LOG2N-1:0] rd_b_q, rd_b_d;
  logic [KW-1:0]    tw_q, tw_d;
  logic             done_q, done_d;

  logic             pend;
  logic             wr_vld;
  logic [2*LOG2N-1:0] wr_data;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          k_d     = '0;
          stage_d = '0;
          rd_en_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (k_q == K_LAST) begin
          k_d = '0;
          if (stage_q == LAST_STAGE) begin
            state_d = ST_DRAIN;
          end else begin
`ifdef FFT_CTRL_HAZARD_EN
            state_d = ST_WAIT;
`else
            stage_d = stage_q + STW'(1);
            rd_en_d = 1'b1;
`endif
          end
        end else begin
          k_d     = k_q + KW'(1);
          rd_en_d = 1'b1;
        end
      end
      ST_WAIT: begin
`ifdef FFT_CTRL_HAZARD_EN
        // Only the stage's final write may remain, and it issues this cycle;
        // the next stage's first read lands on the following cycle.
        if (!pend) begin
          state_d = ST_RUN;
          stage_d = stage_q + STW'(1);
          rd_en_d = 1'b1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DRAIN: begin
        if (!pend) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Addresses and twiddle are registered from the next counter values so
    // they change on the same edge as rd_en; they hold while rd_en is low.
    rd_a_d = rd_a_q;
    rd_b_d = rd_b_q;
    tw_d   = tw_q;
    if (rd_en_d) begin
      rd_a_d = LOG2N'(bfly_addr_a(32'(k_d), 32'(stage_d)));
      rd_b_d = rd_a_d + (LOG2N'(1) << stage_d);
      tw_d   = KW'(bfly_tw(32'(k_d), 32'(stage_d), LOG2N));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      tw_q    <= tw_d;
      done_q  <= done_d;
    end
  end

  // Reset clears the line, so in-flight butterflies never write back.
  fft_addr_dly #(
    .DEPTH (PIPE_LAT),
    .WIDTH (2 * LOG2N)
  ) u_dly (
    .clk    (clk),
    .clr_i  (rst),
    .vld_i  (rd_en_q),
    .data_i ({rd_a_q, rd_b_q}),
    .vld_o  (wr_vld),
    .data_o (wr_data),
    .pend_o (pend)
  );

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_a_q;
  assign bus.rd_addr_b = rd_b_q;
  assign bus.tw_idx    = tw_q;
  assign bus.stage     = stage_q;
  assign bus.wr_en     = wr_vld;
  assign bus.wr_addr_a = wr_data[2*LOG2N-1:LOG2N];
  assign bus.wr_addr_b = wr_data[LOG2N-1:0];

endmodule

// File: tb/tb_fft_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_ctrl
// Bench for fft_ctrl with LOG2N=3, RD_LAT=1, BFU_LAT=4. A reference trace of
// one transform is built from the textbook DIT loop nest (stage / group /
// offset); a small model places that trace in time from the start/reset
// history and predicts every output each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fft_ctrl;

  localparam int LOG2N = 3;
  localparam int N     = 8;
  localparam int HALF  = N / 2;
  localparam int PIPE  = 5;
  localparam int TMAX  = 64;
`ifdef FFT_CTRL_HAZARD_EN
  localparam int GAP       = PIPE;
  localparam int EXP_DONE  = 28;
  localparam int EXP_DONE2 = 56;
`else
  localparam int GAP       = 0;
  localparam int EXP_DONE  = 18;
  localparam int EXP_DONE2 = 36;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_ctrl_if #(.LOG2N(LOG2N)) bus ();

  fft_ctrl #(
    .LOG2N   (LOG2N),
    .RD_LAT  (1),
    .BFU_LAT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // One-transform reference trace, indexed by cycles after start was sampled.
  bit t_rd [TMAX];
  bit t_wr [TMAX];
  int t_a [TMAX], t_b [TMAX], t_tw [TMAX], t_stg [TMAX];
  int t_wa [TMAX], t_wb [TMAX];
  int done_off;

  // Model state.
  bit         m_act;
  int         m_t0;
  bit         post_rst;
  logic [2:0] m_last_a, m_last_b;

  logic [19:0] exp_v, msk_v, obs_v;

  function automatic void build_trace();
    int r, last;
    last = 0;
    for (int o = 0; o < TMAX; o++) begin
      t_rd[o] = 0; t_wr[o] = 0;
      t_a[o] = 0; t_b[o] = 0; t_tw[o] = 0; t_stg[o] = 0; t_wa[o] = 0; t_wb[o] = 0;
    end
    for (int s = 0; s < LOG2N; s++) begin
      int h, idx;
      h   = 1 << s;
      idx = 0;
      for (int g = 0; g < N; g += 2 * h) begin
        for (int j = 0; j < h; j++) begin
          r = 1 + s * (HALF + GAP) + idx;
          t_rd[r] = 1; t_a[r] = g + j; t_b[r] = g + j + h;
          t_tw[r] = j * (N / (2 * h)); t_stg[r] = s;
          t_wr[r + PIPE] = 1; t_wa[r + PIPE] = g + j; t_wb[r + PIPE] = g + j + h;
          idx++;
          last = r;
        end
      end
    end
    done_off = last + PIPE + 1;
  endfunction

  // Advance the model by one edge given the inputs sampled at it, then
  // predict the outputs of the new cycle.
  task automatic model_step(input bit r, input bit s);
    int  o;
    bit  in_run, busy_e, done_e, rd_e, wr_e;
    logic [1:0] tw_e, stg_e;
    logic [2:0] wa_e, wb_e;
    if (r) begin
      m_act = 0; m_last_a = '0; m_last_b = '0; post_rst = 1;
    end else begin
      post_rst = 0;
      if (s && (!m_act || (cyc - m_t0) >= done_off)) begin
        m_act = 1; m_t0 = cyc;
      end
    end
    cyc++;
    o      = m_act ? cyc - m_t0 : -1;
    in_run = m_act && o >= 1 && o <= done_off;
    busy_e = in_run && o < done_off;
    done_e = in_run && o == done_off;
    rd_e   = in_run && t_rd[o];
    wr_e   = in_run && t_wr[o];
    tw_e = '0; stg_e = '0; wa_e = '0; wb_e = '0;
    if (rd_e) begin
      m_last_a = 3'(t_a[o]); m_last_b = 3'(t_b[o]);
      tw_e = 2'(t_tw[o]); stg_e = 2'(t_stg[o]);
    end
    if (wr_e) begin
      wa_e = 3'(t_wa[o]); wb_e = 3'(t_wb[o]);
    end
    exp_v = {busy_e, done_e, rd_e, m_last_a, m_last_b, tw_e, stg_e, wr_e, wa_e, wb_e};
    msk_v = '1;
    if (!post_rst) begin
      if (!rd_e) msk_v[10:7] = '0;
      if (!wr_e) msk_v[5:0]  = '0;
    end
  endtask

  task automatic tick(input bit r, input bit s);
    rst       = r;
    bus.start = s;
    @(posedge clk);
    #1;
    model_step(r, s);
    obs_v = {bus.busy, bus.done, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
             bus.tw_idx, bus.stage, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1, $urandom_range(0, 1) == 1);
      checks++;
      if (obs_v !== 20'h0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%05h exp=00000", cyc, obs_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%05h exp=%05h mask=%05h", cyc, obs_v, exp_v, msk_v);
      end
    end
  endtask

  task automatic test_single();
    int first_rd, first_done, last_wr;
    first_rd = -1; first_done = -1; last_wr = -1;
    for (int i = 0; i <= EXP_DONE + 3; i++) begin
      tick(0, i == 0);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL single cyc=%0d got=%05h exp=%05h mask=%05h", i + 1, obs_v, exp_v, msk_v);
      end
      if (bus.rd_en && first_rd < 0) first_rd = i + 1;
      if (bus.wr_en) last_wr = i + 1;
      if (bus.done && first_done < 0) first_done = i + 1;
    end
    checks++;
    if (first_rd !== 1) begin
      errors++;
      $display("FAIL single_first_rd got=%0d exp=1", first_rd);
    end
    checks++;
    if (last_wr !== EXP_DONE - 1) begin
      errors++;
      $display("FAIL single_last_wr got=%0d exp=%0d", last_wr, EXP_DONE - 1);
    end
    checks++;
    if (first_done !== EXP_DONE) begin
      errors++;
      $display("FAIL single_done got=%0d exp=%0d", first_done, EXP_DONE);
    end
  endtask

  task automatic test_ignore_start();
    for (int i = 0; i <= EXP_DONE + 3; i++) begin
      tick(0, i == 0 || i == 5 || (i > 5 && i < EXP_DONE && $urandom_range(0, 3) == 0));
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL ignore_start cyc=%0d got=%05h exp=%05h mask=%05h", i + 1, obs_v, exp_v, msk_v);
      end
    end
  endtask

  task automatic test_mid_reset();
    int wr_after;
    wr_after = 0;
    for (int i = 0; i <= 12 + EXP_DONE + 3; i++) begin
      tick(i == 8, i == 0 || i == 12);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got=%05h exp=%05h mask=%05h", i + 1, obs_v, exp_v, msk_v);
      end
      if (i >= 8 && i < 12 + PIPE && bus.wr_en) wr_after++;
    end
    checks++;
    if (wr_after !== 0) begin
      errors++;
      $display("FAIL mid_reset_wr got=%0d writes exp=0", wr_after);
    end
  endtask

  task automatic test_back_to_back();
    int d0, d1;
    d0 = -1; d1 = -1;
    for (int i = 0; i <= EXP_DONE2 + 1; i++) begin
      tick(0, 1);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%05h exp=%05h mask=%05h", i + 1, obs_v, exp_v, msk_v);
      end
      if (bus.done) begin
        if (d0 < 0) d0 = i + 1;
        else if (d1 < 0) d1 = i + 1;
      end
    end
    checks++;
    if (d0 !== EXP_DONE || d1 !== EXP_DONE2) begin
      errors++;
      $display("FAIL back_to_back_done got=%0d,%0d exp=%0d,%0d", d0, d1, EXP_DONE, EXP_DONE2);
    end
    // Drop start for a full transform so the last restarted run completes.
    for (int i = 0; i < EXP_DONE + 2; i++) begin
      tick(0, 0);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL back_to_back_tail cyc=%0d got=%05h exp=%05h mask=%05h", cyc, obs_v, exp_v, msk_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      tick($urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);
      checks++;
      if ((obs_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL random cyc=%0d got=%05h exp=%05h mask=%05h", cyc, obs_v, exp_v, msk_v);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    m_act     = 0;
    m_t0      = 0;
    post_rst  = 0;
    m_last_a  = '0;
    m_last_b  = '0;
    build_trace();
    test_reset();
    test_single();
    idle(4);
    test_ignore_start();
    idle(4);
    test_mid_reset();
    idle(4);
    test_back_to_back();
    idle(4);
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
